// File: rtl/dr_link_tx.sv
// Clocked dual-rail link transmitter: two-phase (rail toggle) or four-phase return-to-zero encoding.
// Define DR_LINK_TX_TIMEOUT_EN to enable the sticky ack watchdog (err); otherwise err is tied to 0.
module dr_link_tx #(
  parameter logic [15:0] ENC         = "TP",
  parameter int unsigned WIDTH       = 1,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [WIDTH-1:0]      s_data,
  input  logic                  ack_in,
  output logic [WIDTH-1:0][1:0] out,
  output logic                  err
);

  localparam bit IsFp = (ENC == "FP");

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WAIT_HI = 2'd1;
  localparam logic [1:0] WAIT_LO = 2'd2;
  localparam logic [1:0] WAIT    = 2'd3;

  generate
    if (ENC != "TP" && ENC != "FP") begin : g_bad_enc
      $error("dr_link_tx: ENC must be TP or FP");
    end
    if (WIDTH == 0 || SYNC_STAGES < 2 || TIMEOUT_CYC == 0) begin : g_bad_param
      $error("dr_link_tx: WIDTH>=1, SYNC_STAGES>=2 and TIMEOUT_CYC>=1 required");
    end
  endgenerate

  // Ack synchronizer; the FSM only ever looks at ack_s.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ack_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ack_in};
    end
  end

  assign ack_s = sync_q[SYNC_STAGES-1];

  logic [1:0]            state_q, state_d;
  logic [WIDTH-1:0][1:0] out_q, out_d;
  logic                  phase_q, phase_d;
  logic                  accept;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    phase_d = phase_q;
    s_ready = 1'b0;
    accept  = 1'b0;
    if (IsFp) begin
      case (state_q)
        IDLE: begin
          s_ready = ~ack_s;
          accept  = s_valid & ~ack_s;
          if (accept) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
              out_d[i] = s_data[i] ? 2'b10 : 2'b01;
            end
            state_d = WAIT_HI;
          end
        end
        WAIT_HI: begin
          if (ack_s) begin
            out_d   = '0;
            state_d = WAIT_LO;
          end
        end
        WAIT_LO: begin
          if (!ack_s) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else begin
      case (state_q)
        IDLE: begin
          s_ready = 1'b1;
          accept  = s_valid;
          if (accept) begin
            // Exactly one rail per bit toggles; the toggled rail carries the value.
            for (int unsigned i = 0; i < WIDTH; i++) begin
              out_d[i] = out_q[i] ^ (s_data[i] ? 2'b10 : 2'b01);
            end
            state_d = WAIT;
          end
        end
        WAIT: begin
          if (ack_s != phase_q) begin
            phase_d = ~phase_q;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      out_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      phase_q <= phase_d;
    end
  end

  assign out = out_q;

`ifdef DR_LINK_TX_TIMEOUT_EN
  localparam int unsigned     CntW   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYC);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q;

  // Counts cycles spent in a waiting state; any state change restarts it. Saturates at the limit.
  always_comb begin
    cnt_d = '0;
    if (state_q != IDLE && state_d == state_q) begin
      cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_q | (cnt_d == CntMax);
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_dr_link_tx.sv
// Bench for dr_link_tx: FP (WIDTH=4), TP (WIDTH=1) and TP (WIDTH=4) instances with receiver models
// and a queue of expected link codewords / decoded words.
module tb_dr_link_tx;

  localparam int unsigned Sync = 2;
  localparam int unsigned Tmo  = 16;
`ifdef DR_LINK_TX_TIMEOUT_EN
  localparam bit TimeoutEn = 1'b1;
`else
  localparam bit TimeoutEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic            fp_valid, fp_ready, fp_ack, fp_err;
  logic [3:0]      fp_data;
  logic [3:0][1:0] fp_out;
  logic            tp1_valid, tp1_ready, tp1_ack, tp1_err;
  logic [0:0]      tp1_data;
  logic [0:0][1:0] tp1_out;
  logic            tp4_valid, tp4_ready, tp4_ack, tp4_err;
  logic [3:0]      tp4_data;
  logic [3:0][1:0] tp4_out;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];

  dr_link_tx #(.ENC("FP"), .WIDTH(4), .SYNC_STAGES(Sync), .TIMEOUT_CYC(Tmo)) u_fp (
    .clk(clk), .rst(rst), .s_valid(fp_valid), .s_ready(fp_ready), .s_data(fp_data),
    .ack_in(fp_ack), .out(fp_out), .err(fp_err)
  );

  dr_link_tx #(.ENC("TP"), .WIDTH(1), .SYNC_STAGES(Sync), .TIMEOUT_CYC(Tmo)) u_tp1 (
    .clk(clk), .rst(rst), .s_valid(tp1_valid), .s_ready(tp1_ready), .s_data(tp1_data),
    .ack_in(tp1_ack), .out(tp1_out), .err(tp1_err)
  );

  dr_link_tx #(.ENC("TP"), .WIDTH(4), .SYNC_STAGES(Sync), .TIMEOUT_CYC(Tmo)) u_tp4 (
    .clk(clk), .rst(rst), .s_valid(tp4_valid), .s_ready(tp4_ready), .s_data(tp4_data),
    .ack_in(tp4_ack), .out(tp4_out), .err(tp4_err)
  );

  function automatic logic [7:0] fp_code(input logic [3:0] d);
    logic [7:0] c;
    for (int i = 0; i < 4; i++) c[2*i +: 2] = d[i] ? 2'b10 : 2'b01;
    return c;
  endfunction

  task automatic fp_ack_pulse();
    fp_ack = 1'b1;
    repeat (Sync + 2) @(negedge clk);
    fp_ack = 1'b0;
    repeat (Sync + 2) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [7:0] e;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (fp_out !== 8'h00 || fp_ready !== 1'b1 || fp_err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_fp: out=%h ready=%b err=%b, want 00 1 0", fp_out, fp_ready, fp_err);
    end
    n_cmp++;
    if (tp1_out !== 2'b00 || tp1_ready !== 1'b1 || tp4_out !== 8'h00 || tp4_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_tp: tp1 out=%b rdy=%b tp4 out=%h rdy=%b, want 00 1 00 1",
               tp1_out, tp1_ready, tp4_out, tp4_ready);
    end
    rst = 1'b1;
    @(negedge clk);
    fp_valid = 1'b1;
    fp_data  = 4'hF;
    exp_q.push_back(8'hAA);
    @(negedge clk);
    fp_valid = 1'b0;
    e = exp_q.pop_front();
    n_cmp++;
    if (fp_out !== e) begin
      n_bad++;
      $display("FAIL pre_reset_word: out=%h, want %h", fp_out, e);
    end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if (fp_out !== 8'h00 || fp_ready !== 1'b1 || fp_err !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset: out=%h ready=%b err=%b, want 00 1 0", fp_out, fp_ready, fp_err);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fp_basic();
    logic [7:0] e;
    int lat;
    fp_data  = 4'b1010;
    fp_valid = 1'b1;
    exp_q.push_back(8'b10_01_10_01);
    n_cmp++;
    if (fp_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL fp_ready_idle: ready=%b, want 1", fp_ready);
    end
    @(negedge clk);
    fp_valid = 1'b0;
    fp_data  = 4'($urandom);
    e = exp_q.pop_front();
    n_cmp++;
    if (fp_out !== e || fp_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL fp_codeword: out=%b ready=%b, want %b 0", fp_out, fp_ready, e);
    end
    fp_valid = 1'b1;
    fp_data  = 4'b0101;
    repeat (2) @(negedge clk);
    fp_valid = 1'b0;
    n_cmp++;
    if (fp_out !== e || fp_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL fp_busy_ignore: out=%b ready=%b, want %b 0", fp_out, fp_ready, e);
    end
    fp_ack = 1'b1;
    lat = 0;
    while (fp_out !== 8'h00 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    n_cmp++;
    if (lat != Sync + 1 || fp_out !== 8'h00) begin
      n_bad++;
      $display("FAIL fp_null_latency: cycles=%0d out=%h, want %0d 00", lat, fp_out, Sync + 1);
    end
    fp_ack = 1'b0;
    lat = 0;
    while (fp_ready !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    n_cmp++;
    if (lat != Sync + 1 || fp_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL fp_ready_latency: cycles=%0d ready=%b, want %0d 1", lat, fp_ready, Sync + 1);
    end
  endtask

  task automatic test_tp();
    logic [1:0] steps [3];
    logic       bits  [3];
    logic [7:0] e;
    int lat;
    steps = '{2'b10, 2'b11, 2'b01};
    bits  = '{1'b1, 1'b0, 1'b1};
    n_cmp++;
    if (tp1_out !== 2'b00) begin
      n_bad++;
      $display("FAIL tp_initial: out=%b, want 00", tp1_out);
    end
    for (int k = 0; k < 3; k++) begin
      tp1_valid = 1'b1;
      tp1_data  = bits[k];
      exp_q.push_back({6'b0, steps[k]});
      @(negedge clk);
      tp1_valid = 1'b0;
      tp1_data  = ~bits[k];
      e = exp_q.pop_front();
      n_cmp++;
      if (tp1_out !== e[1:0] || tp1_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL tp_step%0d: out=%b ready=%b, want %b 0", k, tp1_out, tp1_ready, e[1:0]);
      end
      tp1_valid = 1'b1;
      repeat (3) @(negedge clk);
      tp1_valid = 1'b0;
      n_cmp++;
      if (tp1_out !== e[1:0] || tp1_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL tp_hold%0d: out=%b ready=%b, want %b 0", k, tp1_out, tp1_ready, e[1:0]);
      end
      tp1_ack = ~tp1_ack;
      lat = 0;
      while (tp1_ready !== 1'b1 && lat < 10) begin
        @(negedge clk);
        lat++;
      end
      n_cmp++;
      if (lat != Sync + 1) begin
        n_bad++;
        $display("FAIL tp_ready%0d: cycles=%0d, want %0d", k, lat, Sync + 1);
      end
    end
  endtask

  task automatic test_back_to_back_fp();
    logic [3:0] words [3];
    logic [3:0] w;
    logic [7:0] e;
    logic       acc, all_ok;
    int idx, got, cyc;
    words = '{4'h3, 4'hC, 4'h5};
    idx = 0;
    got = 0;
    cyc = 0;
    fp_valid = 1'b1;
    fp_data  = words[0];
    exp_q.push_back({4'h0, words[0]});
    while (cyc < 200 && !(got == 3 && !fp_ack && fp_ready)) begin
      acc = fp_valid & fp_ready;
      @(negedge clk);
      cyc++;
      all_ok = 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (fp_out[i] != 2'b10 && fp_out[i] != 2'b01) all_ok = 1'b0;
        w[i] = fp_out[i][1];
      end
      if (!fp_ack && all_ok) begin
        got++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL b2b_fp_extra: got %h, want no word", w);
        end else begin
          e = exp_q.pop_front();
          if (w !== e[3:0]) begin
            n_bad++;
            $display("FAIL b2b_fp_word%0d: got %h, want %h", got, w, e[3:0]);
          end
        end
        fp_ack = 1'b1;
      end else if (fp_ack && fp_out === 8'h00) begin
        fp_ack = 1'b0;
      end
      if (acc) begin
        idx++;
        if (idx < 3) begin
          fp_data = words[idx];
          exp_q.push_back({4'h0, words[idx]});
        end else begin
          fp_valid = 1'b0;
        end
      end
    end
    fp_valid = 1'b0;
    n_cmp++;
    if (got != 3 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL b2b_fp_count: got %0d left %0d, want 3 0", got, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_back_to_back_tp();
    logic [3:0]      words [3];
    logic [3:0][1:0] prev, d;
    logic [3:0]      w;
    logic [7:0]      e;
    logic            acc, all_ok;
    int idx, got, cyc;
    words = '{4'h3, 4'hC, 4'h5};
    prev = tp4_out;
    idx = 0;
    got = 0;
    cyc = 0;
    tp4_valid = 1'b1;
    tp4_data  = words[0];
    exp_q.push_back({4'h0, words[0]});
    while (cyc < 200 && !(got == 3 && tp4_ready)) begin
      acc = tp4_valid & tp4_ready;
      @(negedge clk);
      cyc++;
      d = tp4_out ^ prev;
      if (d != 8'h00) begin
        all_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
          if (d[i] != 2'b10 && d[i] != 2'b01) all_ok = 1'b0;
          w[i] = d[i][1];
        end
        got++;
        n_cmp++;
        if (!all_ok || exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL b2b_tp_bad: rail change %b queued %0d, want one rail per bit", d,
                   exp_q.size());
        end else begin
          e = exp_q.pop_front();
          if (w !== e[3:0]) begin
            n_bad++;
            $display("FAIL b2b_tp_word%0d: got %h, want %h", got, w, e[3:0]);
          end
        end
        prev    = tp4_out;
        tp4_ack = ~tp4_ack;
      end
      if (acc) begin
        idx++;
        if (idx < 3) begin
          tp4_data = words[idx];
          exp_q.push_back({4'h0, words[idx]});
        end else begin
          tp4_valid = 1'b0;
        end
      end
    end
    tp4_valid = 1'b0;
    n_cmp++;
    if (got != 3 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL b2b_tp_count: got %0d left %0d, want 3 0", got, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset_wait_hi();
    logic [7:0] e;
    logic ok;
    int lat;
    fp_valid = 1'b1;
    fp_data  = 4'h6;
    exp_q.push_back(fp_code(4'h6));
    @(negedge clk);
    fp_valid = 1'b0;
    e = exp_q.pop_front();
    n_cmp++;
    if (fp_out !== e) begin
      n_bad++;
      $display("FAIL rst_hi_word: out=%b, want %b", fp_out, e);
    end
    fp_ack  = 1'b1;
    tp1_ack = 1'b0;
    tp4_ack = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if (fp_out !== 8'h00) begin
      n_bad++;
      $display("FAIL rst_hi_async: out=%h, want 00", fp_out);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (Sync) @(negedge clk);
    ok = 1'b1;
    repeat (5) begin
      if (fp_ready !== 1'b0) ok = 1'b0;
      @(negedge clk);
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL rst_hi_ready_low: ready went %b with ack high, want 0", ok);
    end
    fp_ack = 1'b0;
    lat = 0;
    while (fp_ready !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    n_cmp++;
    if (lat != Sync) begin
      n_bad++;
      $display("FAIL rst_hi_ready_return: cycles=%0d, want %0d", lat, Sync);
    end
    fp_valid = 1'b1;
    fp_data  = 4'h9;
    exp_q.push_back(fp_code(4'h9));
    @(negedge clk);
    fp_valid = 1'b0;
    e = exp_q.pop_front();
    n_cmp++;
    if (fp_out !== e) begin
      n_bad++;
      $display("FAIL rst_hi_next_word: out=%b, want %b", fp_out, e);
    end
    fp_ack_pulse();
    n_cmp++;
    if (fp_out !== 8'h00 || fp_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_hi_complete: out=%h ready=%b, want 00 1", fp_out, fp_ready);
    end
  endtask

  task automatic test_timeout();
    n_cmp++;
    if (fp_err !== 1'b0) begin
      n_bad++;
      $display("FAIL tmo_clear: err=%b, want 0", fp_err);
    end
    fp_valid = 1'b1;
    fp_data  = 4'h1;
    @(negedge clk);
    fp_valid = 1'b0;
    repeat (Tmo - 1) @(negedge clk);
    n_cmp++;
    if (fp_err !== 1'b0) begin
      n_bad++;
      $display("FAIL tmo_before: err=%b, want 0", fp_err);
    end
    @(negedge clk);
    n_cmp++;
    if (fp_err !== TimeoutEn) begin
      n_bad++;
      $display("FAIL tmo_at_limit: err=%b, want %b", fp_err, TimeoutEn);
    end
    repeat (5) @(negedge clk);
    fp_ack_pulse();
    n_cmp++;
    if (fp_out !== 8'h00 || fp_ready !== 1'b1 || fp_err !== TimeoutEn) begin
      n_bad++;
      $display("FAIL tmo_sticky: out=%h ready=%b err=%b, want 00 1 %b", fp_out, fp_ready, fp_err,
               TimeoutEn);
    end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if (fp_err !== 1'b0) begin
      n_bad++;
      $display("FAIL tmo_reset_clear: err=%b, want 0", fp_err);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    fp_valid  = 1'b0;
    fp_data   = '0;
    fp_ack    = 1'b0;
    tp1_valid = 1'b0;
    tp1_data  = '0;
    tp1_ack   = 1'b0;
    tp4_valid = 1'b0;
    tp4_data  = '0;
    tp4_ack   = 1'b0;
    test_reset();
    test_fp_basic();
    test_tp();
    test_back_to_back_fp();
    test_back_to_back_tp();
    test_reset_wait_hi();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
